elevator_ctrl: RTL
==================

# elevator_ctrl

Car-motion controller for the elevator subsystem. Accepts one resolved target floor at a time from the request-resolution logic, drives the car up or down one floor per travel interval, then holds the door open for a fixed dwell. It owns the car position register and produces the `up`/`down`/`open` status that the request logic consumes.

## Interface
Parameters:
- NUM_FLOORS, 10, number of floors; floors are numbered 0..NUM_FLOORS-1.
- FLOOR_BITS, $clog2(NUM_FLOORS), width of floor numbers.
- TRAVEL_CYCLES, 8, clock cycles to travel one floor; must be >= 2.
- DOOR_CYCLES, 16, clock cycles the door stays open; must be >= 2.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- resetN  in  1  asynchronous, active-low reset.
- req  in  FLOOR_BITS  target floor.
- req_valid  in  1  `req` is valid this cycle.
- req_ready  out  1  controller can accept a request; equals (state == IDLE).
- door_hold  in  1  door-reopen/hold button; sampled only in DOOR_OPEN.
- floor  out  FLOOR_BITS  current car floor, registered.
- up  out  1  car moving up, registered.
- down  out  1  car moving down, registered.
- open  out  1  door open, registered.
- arrived  out  1  one-cycle pulse on the first DOOR_OPEN cycle.
- req_err  out  1  one-cycle pulse when an out-of-range request is accepted.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- Accept: the request is accepted on a rising edge where req_valid & req_ready. `req` is latched into the FLOOR_BITS `target` register.
- Transitions out of IDLE on accept:
  - req >= NUM_FLOORS: stay in IDLE and pulse req_err.
  - req == floor: go to DOOR_OPEN.
  - req > floor: go to MOVE_UP.
  - req < floor: go to MOVE_DOWN.
- MOVE_UP / MOVE_DOWN:
  - Travel counter tcnt counts 0..TRAVEL_CYCLES-1.
  - When tcnt == TRAVEL_CYCLES-1, floor increments (MOVE_UP) or decrements (MOVE_DOWN) and tcnt clears.
  - If the new floor equals target, go to DOOR_OPEN.
  - floor never wraps: it stays within 0..NUM_FLOORS-1 by construction.
- DOOR_OPEN:
  - Door counter dcnt counts 0..DOOR_CYCLES-1.
  - When dcnt == DOOR_CYCLES-1 and door_hold == 0, go to IDLE.
  - door_hold == 1 clears dcnt, extending the dwell; holding it indefinitely keeps the door open indefinitely.
- Requests while busy: not accepted (req_ready = 0). The requester holds req_valid/req until accepted.
- Output encoding: up = (state == MOVE_UP), down = (state == MOVE_DOWN), open = (state == DOOR_OPEN). These are registered from next_state, so at most one is ever high.

## Timing
- Reset values:
  - State IDLE, floor 0, target 0, tcnt 0, dcnt 0.
  - up, down, open, arrived, req_err all 0.
  - req_ready is 1 during and after reset.
- Reset mid-operation takes effect immediately and asynchronously. The car position returns to 0; recalibration is out of scope.
- Accept on edge E0: up or down is high from E0 and floor first changes at E0 + TRAVEL_CYCLES.
- For a distance of d floors:
  - open rises at E0 + d*TRAVEL_CYCLES and stays high for DOOR_CYCLES cycles when door_hold is never asserted.
  - req_ready returns at E0 + d*TRAVEL_CYCLES + DOOR_CYCLES.
- Same-floor request: open is high from E0 for DOOR_CYCLES cycles.
- Out-of-range request: req_err is high for the single cycle after E0; req_ready stays 1.
- arrived is coincident with the first cycle of open high.
- Counter widths are $clog2(TRAVEL_CYCLES) and $clog2(DOOR_CYCLES). Floor comparisons are unsigned at FLOOR_BITS. The range check compares req against NUM_FLOORS at FLOOR_BITS+1 bits.

## Structure
- `elevator_pkg` holds the `ctrl_state_t` enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN) and the shared NUM_FLOORS default, so the request-resolution logic can use the same definitions.
- One sub-module, `cycle_timer`:
  - Parameter CYCLES.
  - Inputs: clear, enable. Output: done, asserted when count == CYCLES-1.
  - Instantiated twice, once for travel and once for the door.

## Test plan
All scenarios use TRAVEL_CYCLES=4, DOOR_CYCLES=6.
- Reset, then idle: floor=0, up=down=open=0, req_ready=1; no state change with req_valid=0.
- Request 3 from floor 0:
  - up high for 12 cycles; floor becomes 1, 2, 3 at +4, +8, +12.
  - open and arrived asserted at +12; open high for 6 cycles.
  - req_ready returns at +18.
- From floor 3, request 1: down high for 8 cycles, floor reaches 1 at +8, then open for 6 cycles. Issue a second request of 5 while busy: it is held off until req_ready returns, then accepted.
- From floor 2, request 2: open high from +0 for 6 cycles, arrived pulse, up=down=0 throughout. Assert door_hold for 3 cycles mid-dwell: open stays high until 6 cycles after door_hold falls.
- Request 12 (>= NUM_FLOORS): req_err pulses once, state stays IDLE, floor is unchanged.
- Assert resetN low during a move at floor 2: all outputs return to reset values immediately and floor=0; the next request of 1 behaves normally.

Source files
------------

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared controller state encoding and floor-count default
package elevator_pkg;
  localparam int DEF_NUM_FLOORS = 10;
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} ctrl_state_t;
endpackage

// File: rtl/elevator_ctrl_if.sv
// elevator_ctrl_if: request handshake, door button and car status bundle
interface elevator_ctrl_if #(parameter int FLOOR_BITS = 4);
  logic [FLOOR_BITS-1:0] req;
  logic req_valid;
  logic req_ready;
  logic door_hold;
  logic [FLOOR_BITS-1:0] floor;
  logic up;
  logic down;
  logic open;
  logic arrived;
  logic req_err;
  modport master (
    output req, req_valid, door_hold,
    input req_ready, floor, up, down, open, arrived, req_err
  );
  modport slave (
    input req, req_valid, door_hold,
    output req_ready, floor, up, down, open, arrived, req_err
  );
endinterface

// File: rtl/cycle_timer.sv
// cycle_timer: wrapping interval counter flagging the last cycle of each interval
module cycle_timer #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam int W = $clog2(CYCLES);
  logic [W-1:0] count;
  assign done = count == W'(CYCLES - 1);
  // count while enabled, wrap after the last cycle, clear has priority
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) count <= '0;
    else if (clear) count <= '0;
    else if (enable) count <= done ? '0 : count + W'(1);
endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: car-motion controller driving travel between floors and door dwell
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int FLOOR_BITS    = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input logic clk,
  input logic resetN,
  elevator_ctrl_if.slave bus
);
  ctrl_state_t state, next_state;
  logic [FLOOR_BITS-1:0] target, step_floor;
  logic accept, out_range, moving, t_done, d_done;
  assign bus.req_ready = state == IDLE;
  assign accept = bus.req_valid & bus.req_ready;
  assign out_range = {1'b0, bus.req} >= (FLOOR_BITS + 1)'(NUM_FLOORS);
  assign moving = state == MOVE_UP || state == MOVE_DOWN;
  assign step_floor = state == MOVE_DOWN ? bus.floor - FLOOR_BITS'(1) : bus.floor + FLOOR_BITS'(1);
  cycle_timer #(.CYCLES(TRAVEL_CYCLES)) u_travel (
    .clk(clk), .resetN(resetN), .clear(!moving), .enable(moving), .done(t_done)
  );
  cycle_timer #(.CYCLES(DOOR_CYCLES)) u_door (
    .clk(clk), .resetN(resetN), .clear(state != DOOR_OPEN || bus.door_hold),
    .enable(state == DOOR_OPEN), .done(d_done)
  );
  // state register
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) state <= IDLE;
    else state <= next_state;
  // next state: dispatch on accept, stop at target, close door after dwell
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept && !out_range)
                   next_state = bus.req == bus.floor ? DOOR_OPEN : bus.req > bus.floor ? MOVE_UP : MOVE_DOWN;
      MOVE_UP,
      MOVE_DOWN: if (t_done && step_floor == target) next_state = DOOR_OPEN;
      DOOR_OPEN: if (d_done && !bus.door_hold) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end
  // car position, latched target and registered status outputs
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      bus.floor   <= '0;
      target      <= '0;
      bus.up      <= 1'b0;
      bus.down    <= 1'b0;
      bus.open    <= 1'b0;
      bus.arrived <= 1'b0;
      bus.req_err <= 1'b0;
    end else begin
      if (accept) target <= bus.req;
      if (moving && t_done) bus.floor <= step_floor;
      bus.up      <= next_state == MOVE_UP;
      bus.down    <= next_state == MOVE_DOWN;
      bus.open    <= next_state == DOOR_OPEN;
      bus.arrived <= next_state == DOOR_OPEN && state != DOOR_OPEN;
      bus.req_err <= accept && out_range;
    end
endmodule
